axis_reg_array: RTL and testbench

Parametrised AXI4-Stream register pipeline for timing closure on wide datapaths in the shell and user regions. It is plain RTL, so it works at any data width and does not depend on vendor register-slice IP. It chains `STAGES` identical register stages, each built as a full-throughput skid buffer or a lighter forward-only register, selected by `REG_MODE`. It is inserted between any AXI4S master and slave, for example across SLR crossings or between the host DMA and the user logic.

---
 rtl/axis_reg_array_pkg.sv | 20 ++
 rtl/axis_reg_array_if.sv | 20 ++
 rtl/axis_reg_array_stage.sv | 127 ++++++++++++
 rtl/axis_reg_array.sv | 60 ++++++
 tb/tb_axis_reg_array.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_reg_array_pkg.sv
// Shared types for the AXI4-Stream register pipeline: register-stage modes,
// the full-mode stage state encoding and the default stream width.
package lynxTypes;

  localparam int unsigned AXI_DATA_BITS = 512;

  typedef enum logic [1:0] {
    REG_MODE_BYPASS = 2'd0,
    REG_MODE_FWD    = 2'd1,
    REG_MODE_FULL   = 2'd2
  } reg_mode_t;

  // Bit 0 is the main-register valid, bit 1 the skid-register valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } stage_state_t;

endpackage

// File: rtl/axis_reg_array_if.sv
// AXI4-Stream bundle: the master drives tvalid/tdata/tkeep/tlast, the slave
// drives tready.
interface AXI4S
  import lynxTypes::*;
#(
  parameter int unsigned DATA_BITS = AXI_DATA_BITS
) ();

  localparam int unsigned KEEP_BITS = DATA_BITS / 8;

  logic                 tvalid;
  logic                 tready;
  logic [DATA_BITS-1:0] tdata;
  logic [KEEP_BITS-1:0] tkeep;
  logic                 tlast;

  modport m (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport s (input tvalid, input tdata, input tkeep, input tlast, output tready);

endinterface

// File: rtl/axis_reg_array_stage.sv
// One AXI4-Stream register stage: full skid buffer, forward-only register,
// or plain wires, chosen by REG_MODE.
module axis_reg_stage
  import lynxTypes::*;
#(
  parameter int unsigned DATA_BITS = AXI_DATA_BITS,
  parameter reg_mode_t   REG_MODE  = REG_MODE_FULL
) (
  input  logic aclk,
  input  logic aresetn,
  AXI4S.s      s_axis,
  AXI4S.m      m_axis
);

  localparam int unsigned KEEP_BITS = DATA_BITS / 8;
  localparam int unsigned PL_BITS   = DATA_BITS + KEEP_BITS + 1;

  generate
    if (REG_MODE == REG_MODE_FULL) begin : g_full
      stage_state_t       state_q, state_d;
      logic               rdy_q, rdy_d;
      logic [PL_BITS-1:0] s_pl;
      logic [PL_BITS-1:0] main_q, skid_q;
      logic               in_acc, out_tk;
      logic               main_ld_in, main_ld_skid, skid_ld;

      assign s_pl   = {s_axis.tdata, s_axis.tkeep, s_axis.tlast};
      assign in_acc = s_axis.tvalid & rdy_q;
      assign out_tk = m_axis.tready & state_q[0];

      // Valid/ready state; payload flops below deliberately carry no reset.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          state_q <= ST_EMPTY;
          rdy_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          rdy_q   <= rdy_d;
        end
      end

      always_comb begin
        state_d      = state_q;
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        case (state_q)
          ST_EMPTY: begin
            if (in_acc) begin
              state_d    = ST_BUSY;
              main_ld_in = 1'b1;
            end
          end
          ST_BUSY: begin
            if (in_acc && !out_tk) begin
              state_d = ST_FULL;
              skid_ld = 1'b1;
            end else if (out_tk && !in_acc) begin
              state_d = ST_EMPTY;
            end else if (in_acc && out_tk) begin
              main_ld_in = 1'b1;
            end
          end
          ST_FULL: begin
            if (out_tk) begin
              state_d      = ST_BUSY;
              main_ld_skid = 1'b1;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
        rdy_d = (state_d != ST_FULL);
      end

      always_ff @(posedge aclk) begin
        if (main_ld_in) begin
          main_q <= s_pl;
        end else if (main_ld_skid) begin
          main_q <= skid_q;
        end
        if (skid_ld) begin
          skid_q <= s_pl;
        end
      end

      assign s_axis.tready = rdy_q;
      assign m_axis.tvalid = state_q[0];
      assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast} = main_q;

    end else if (REG_MODE == REG_MODE_FWD) begin : g_fwd
      logic               main_v_q;
      logic               rdy_c;
      logic [PL_BITS-1:0] s_pl;
      logic [PL_BITS-1:0] main_q;

      assign s_pl  = {s_axis.tdata, s_axis.tkeep, s_axis.tlast};
      // An empty register can always take a beat; a full one only as it drains.
      assign rdy_c = ~main_v_q | m_axis.tready;

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          main_v_q <= 1'b0;
        end else if (rdy_c) begin
          main_v_q <= s_axis.tvalid;
        end
      end

      always_ff @(posedge aclk) begin
        if (rdy_c) begin
          main_q <= s_pl;
        end
      end

      assign s_axis.tready = rdy_c;
      assign m_axis.tvalid = main_v_q;
      assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast} = main_q;

    end else begin : g_wire
      assign m_axis.tvalid = s_axis.tvalid;
      assign m_axis.tdata  = s_axis.tdata;
      assign m_axis.tkeep  = s_axis.tkeep;
      assign m_axis.tlast  = s_axis.tlast;
      assign s_axis.tready = m_axis.tready;
    end
  endgenerate

endmodule

// File: rtl/axis_reg_array.sv
// AXI4-Stream register pipeline: STAGES chained register stages for timing
// closure on wide datapaths, or a straight wire in bypass mode.
module axis_reg_array
  import lynxTypes::*;
#(
  parameter int unsigned DATA_BITS = AXI_DATA_BITS,
  parameter int unsigned STAGES    = 1,
  parameter reg_mode_t   REG_MODE  = REG_MODE_FULL
) (
  input  logic aclk,
  input  logic aresetn,
  AXI4S.s      s_axis,
  AXI4S.m      m_axis
);

  generate
    if (DATA_BITS % 8 != 0) begin : g_chk_width
      $error("axis_reg_array: DATA_BITS (%0d) must be a multiple of 8", DATA_BITS);
    end
    if (STAGES == 0 || STAGES > 8) begin : g_chk_stages
      $error("axis_reg_array: STAGES (%0d) must be within 1..8", STAGES);
    end

    if (REG_MODE == REG_MODE_BYPASS) begin : g_bypass
      assign m_axis.tvalid = s_axis.tvalid;
      assign m_axis.tdata  = s_axis.tdata;
      assign m_axis.tkeep  = s_axis.tkeep;
      assign m_axis.tlast  = s_axis.tlast;
      assign s_axis.tready = m_axis.tready;
    end else begin : g_pipe
      // link[i] feeds stage i; link[STAGES] is the pipeline output.
      AXI4S #(.DATA_BITS(DATA_BITS)) link [0:STAGES] ();

      assign link[0].tvalid = s_axis.tvalid;
      assign link[0].tdata  = s_axis.tdata;
      assign link[0].tkeep  = s_axis.tkeep;
      assign link[0].tlast  = s_axis.tlast;
      assign s_axis.tready  = link[0].tready;

      for (genvar i = 0; i < int'(STAGES); i++) begin : g_stage
        axis_reg_stage #(
          .DATA_BITS (DATA_BITS),
          .REG_MODE  (REG_MODE)
        ) u_stage (
          .aclk    (aclk),
          .aresetn (aresetn),
          .s_axis  (link[i]),
          .m_axis  (link[i+1])
        );
      end

      assign m_axis.tvalid        = link[STAGES].tvalid;
      assign m_axis.tdata         = link[STAGES].tdata;
      assign m_axis.tkeep         = link[STAGES].tkeep;
      assign m_axis.tlast         = link[STAGES].tlast;
      assign link[STAGES].tready  = m_axis.tready;
    end
  endgenerate

endmodule

// File: tb/tb_axis_reg_array.sv
// Bench for axis_reg_array: FULL, FWD and BYPASS instances checked against a
// queue model of the stream plus hand-computed timing/capacity expectations.
module tb_axis_reg_array;
  import lynxTypes::*;

  localparam int unsigned FB = 128;
  localparam int unsigned FS = 3;
  localparam int unsigned WB = 64;
  localparam int unsigned WS = 2;
  localparam int unsigned BB = 32;

  logic clk = 1'b0;
  logic aresetn;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  AXI4S #(.DATA_BITS(FB)) f_s (), f_m ();
  AXI4S #(.DATA_BITS(WB)) w_s (), w_m ();
  AXI4S #(.DATA_BITS(BB)) b_s (), b_m ();

  axis_reg_array #(.DATA_BITS(FB), .STAGES(FS), .REG_MODE(REG_MODE_FULL)) u_full (
    .aclk(clk), .aresetn(aresetn), .s_axis(f_s), .m_axis(f_m));
  axis_reg_array #(.DATA_BITS(WB), .STAGES(WS), .REG_MODE(REG_MODE_FWD)) u_fwd (
    .aclk(clk), .aresetn(aresetn), .s_axis(w_s), .m_axis(w_m));
  axis_reg_array #(.DATA_BITS(BB), .STAGES(1), .REG_MODE(REG_MODE_BYPASS)) u_byp (
    .aclk(clk), .aresetn(aresetn), .s_axis(b_s), .m_axis(b_m));

  typedef struct {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
    int           c;
  } beat_t;

  beat_t fq[$];
  beat_t wq[$];

  // Source/sink controls (rdy_mode: 0 always, 1 random, 2 stalled, 3 toggling)
  bit f_en = 0, f_rand_v = 0, f_rand_d = 0, f_exact = 0, f_s_hs = 0;
  int f_seq = 0, f_lim = 0, f_pkt = 1, f_rdy_mode = 0, f_in_cnt = 0, f_out_cnt = 0;
  bit w_en = 0, w_rand_v = 0, w_rand_d = 0, w_exact = 0, w_s_hs = 0;
  int w_seq = 0, w_lim = 0, w_pkt = 1, w_rdy_mode = 0, w_in_cnt = 0, w_out_cnt = 0;

  logic [127:0] f_log_d [0:31];
  logic         f_log_l [0:31];
  int           f_log_c [0:31];
  logic [127:0] w_log_d [0:31];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_outs(input string nm, input int f_target, input int w_target, input int budget);
    int n = 0;
    while ((f_out_cnt < f_target || w_out_cnt < w_target) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (f_out_cnt < f_target || w_out_cnt < w_target) begin
      failures++;
      $display("FAIL %s: timeout, outputs full=%0d/%0d fwd=%0d/%0d", nm,
               f_out_cnt, f_target, w_out_cnt, w_target);
    end
  endtask

  // FULL-instance source: holds each beat until it is accepted
  initial begin
    f_s.tvalid = 1'b0; f_s.tdata = '0; f_s.tkeep = '0; f_s.tlast = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!aresetn) begin
        f_s.tvalid = 1'b0;
      end else begin
        if (f_s_hs) f_seq++;
        if (f_s_hs || !f_s.tvalid) begin
          if (f_en && f_seq < f_lim && (!f_rand_v || $urandom_range(1, 0) == 1)) begin
            f_s.tvalid = 1'b1;
            f_s.tdata  = f_rand_d ? {$urandom(), $urandom(), $urandom(), $urandom()} : FB'(f_seq);
            f_s.tkeep  = 16'(f_seq * 37 + 5);
            f_s.tlast  = ((f_seq % f_pkt) == f_pkt - 1);
          end else begin
            f_s.tvalid = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    f_m.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (f_rdy_mode)
        0:       f_m.tready = 1'b1;
        1:       f_m.tready = 1'($urandom_range(1, 0));
        2:       f_m.tready = 1'b0;
        default: f_m.tready = ~f_m.tready;
      endcase
    end
  end

  // FWD-instance source and sink
  initial begin
    w_s.tvalid = 1'b0; w_s.tdata = '0; w_s.tkeep = '0; w_s.tlast = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!aresetn) begin
        w_s.tvalid = 1'b0;
      end else begin
        if (w_s_hs) w_seq++;
        if (w_s_hs || !w_s.tvalid) begin
          if (w_en && w_seq < w_lim && (!w_rand_v || $urandom_range(1, 0) == 1)) begin
            w_s.tvalid = 1'b1;
            w_s.tdata  = w_rand_d ? {$urandom(), $urandom()} : WB'(w_seq);
            w_s.tkeep  = 8'h0F;
            w_s.tlast  = ((w_seq % w_pkt) == w_pkt - 1);
          end else begin
            w_s.tvalid = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    w_m.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (w_rdy_mode)
        0:       w_m.tready = 1'b1;
        1:       w_m.tready = 1'($urandom_range(1, 0));
        2:       w_m.tready = 1'b0;
        default: w_m.tready = ~w_m.tready;
      endcase
    end
  end

  // Compare process: stream model is an in-order queue of accepted beats
  always @(negedge clk) begin : p_compare
    beat_t b;
    if (!aresetn) begin
      fq.delete(); wq.delete();
      f_s_hs = 1'b0; w_s_hs = 1'b0;
      check("full_rst_tvalid", 128'(f_m.tvalid), 128'(0));
      check("full_rst_tready", 128'(f_s.tready), 128'(0));
      check("fwd_rst_tvalid",  128'(w_m.tvalid), 128'(0));
      check("fwd_rst_tready",  128'(w_s.tready), 128'(1));
    end else begin
      f_s_hs = f_s.tvalid & f_s.tready;
      if (f_m.tvalid && f_m.tready) begin
        if (fq.size() == 0) begin
          check("full_spurious_beat", 128'(f_m.tdata), 128'(fq.size()));
        end else begin
          b = fq.pop_front();
          check("full_tdata", 128'(f_m.tdata), b.d);
          check("full_tkeep", 128'(f_m.tkeep), 128'(b.k));
          check("full_tlast", 128'(f_m.tlast), 128'(b.l));
          if (f_exact) check("full_latency", 128'(cyc - b.c), 128'(FS));
          if (f_out_cnt < 32) begin
            f_log_d[f_out_cnt] = 128'(f_m.tdata);
            f_log_l[f_out_cnt] = f_m.tlast;
            f_log_c[f_out_cnt] = cyc;
          end
          f_out_cnt++;
        end
      end
      if (f_s_hs) begin
        b.d = 128'(f_s.tdata); b.k = 16'(f_s.tkeep); b.l = f_s.tlast; b.c = cyc;
        fq.push_back(b);
        f_in_cnt++;
      end
      check("full_capacity", 128'(fq.size() <= int'(2 * FS)), 128'(1));

      // Every FWD stage full means tready is exactly the downstream tready.
      check("fwd_tready", 128'(w_s.tready), 128'((wq.size() < int'(WS)) || w_m.tready));
      w_s_hs = w_s.tvalid & w_s.tready;
      if (w_m.tvalid && w_m.tready) begin
        if (wq.size() == 0) begin
          check("fwd_spurious_beat", 128'(w_m.tdata), 128'(wq.size()));
        end else begin
          b = wq.pop_front();
          check("fwd_tdata", 128'(w_m.tdata), b.d);
          check("fwd_tkeep", 128'(w_m.tkeep), 128'(8'h0F));
          check("fwd_tlast", 128'(w_m.tlast), 128'(b.l));
          if (w_exact) check("fwd_latency", 128'(cyc - b.c), 128'(WS));
          if (w_out_cnt < 32) w_log_d[w_out_cnt] = 128'(w_m.tdata);
          w_out_cnt++;
        end
      end
      if (w_s_hs) begin
        b.d = 128'(w_s.tdata); b.k = 16'(w_s.tkeep); b.l = w_s.tlast; b.c = cyc;
        wq.push_back(b);
        w_in_cnt++;
      end
    end
  end

  initial begin : p_watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : p_main
    int t0;
    aresetn = 1'b0;

    // Bypass: pure wires in both directions
    b_s.tvalid = 1'b1; b_s.tdata = 32'hDEAD_BEEF; b_s.tkeep = 4'hA; b_s.tlast = 1'b1;
    b_m.tready = 1'b0;
    #1;
    check("byp_tvalid", 128'(b_m.tvalid), 128'(1));
    check("byp_tdata",  128'(b_m.tdata),  128'(32'hDEAD_BEEF));
    check("byp_tkeep",  128'(b_m.tkeep),  128'(4'hA));
    check("byp_tlast",  128'(b_m.tlast),  128'(1));
    check("byp_tready_lo", 128'(b_s.tready), 128'(0));
    b_m.tready = 1'b1; b_s.tdata = 32'h1234_5678; b_s.tlast = 1'b0;
    #1;
    check("byp_tready_hi", 128'(b_s.tready), 128'(1));
    check("byp_tdata2",    128'(b_m.tdata),  128'(32'h1234_5678));
    check("byp_tlast2",    128'(b_m.tlast),  128'(0));

    // Reset held 5 cycles; FULL tready rises one edge after release
    repeat (5) @(negedge clk);
    #1;
    aresetn = 1'b1;
    #1;
    check("full_tready_at_release", 128'(f_s.tready), 128'(0));
    @(negedge clk); #1;
    check("full_tready_after_edge", 128'(f_s.tready), 128'(1));
    check("full_tvalid_idle",       128'(f_m.tvalid), 128'(0));

    // Streaming: 16 beats, tdata=i, tlast on 15, exact 3-cycle latency
    f_seq = 0; f_lim = 16; f_pkt = 16; f_exact = 1; f_out_cnt = 0; f_rdy_mode = 0;
    t0 = cyc + 1;
    f_en = 1;
    wait_outs("stream_wait", 16, 0, 100);
    for (int k = 0; k < 16; k++) begin
      check("stream_data",  f_log_d[k], 128'(k));
      check("stream_last",  128'(f_log_l[k]), 128'(k == 15));
      check("stream_cycle", 128'(f_log_c[k]), 128'(t0 + 3 + k));
    end
    f_en = 0; f_exact = 0;
    repeat (4) @(negedge clk);
    #1;

    // Stall: 5 stalled cycles; tready falls after 3 cycles, 6 beats held
    f_seq = 1000; f_lim = 1040; f_pkt = 8; f_out_cnt = 0; f_en = 1;
    repeat (8) @(negedge clk);
    #1;
    check("stall_pre_inflight", 128'(fq.size()), 128'(3));
    f_rdy_mode = 2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check("stall_s_tready", 128'(f_s.tready), 128'(k < 3));
    end
    check("stall_held_beats", 128'(fq.size()), 128'(6));
    check("stall_m_tvalid",   128'(f_m.tvalid), 128'(1));
    f_rdy_mode = 0;
    wait_outs("stall_drain", 40, 0, 200);
    check("stall_out_count", 128'(f_out_cnt), 128'(40));
    check("stall_queue_empty", 128'(fq.size()), 128'(0));
    f_en = 0;

    // FWD: fixed latency with ready held high, then toggling ready
    w_seq = 0; w_lim = 8; w_pkt = 8; w_exact = 1; w_out_cnt = 0; w_rdy_mode = 0; w_en = 1;
    wait_outs("fwd_stream_wait", 0, 8, 100);
    w_exact = 0;
    repeat (2) @(negedge clk);
    #1;
    w_seq = 0; w_lim = 20; w_pkt = 20; w_out_cnt = 0; w_rdy_mode = 3;
    wait_outs("fwd_toggle_wait", 0, 20, 200);
    for (int k = 0; k < 20; k++) check("fwd_toggle_order", w_log_d[k], 128'(k));
    w_en = 0; w_rdy_mode = 0;
    repeat (4) @(negedge clk);
    #1;

    // Random traffic on both instances
    f_seq = 0; f_lim = 4000; f_pkt = 13; f_rand_v = 1; f_rand_d = 1; f_rdy_mode = 1; f_out_cnt = 0;
    w_seq = 0; w_lim = 4000; w_pkt = 11; w_rand_v = 1; w_rand_d = 1; w_rdy_mode = 1; w_out_cnt = 0;
    f_en = 1; w_en = 1;
    wait_outs("random_wait", 4000, 4000, 40000);
    f_rdy_mode = 0; w_rdy_mode = 0;
    repeat (10) @(negedge clk);
    #1;
    check("random_full_count", 128'(f_out_cnt), 128'(4000));
    check("random_fwd_count",  128'(w_out_cnt), 128'(4000));
    check("random_full_empty", 128'(fq.size()), 128'(0));
    check("random_fwd_empty",  128'(wq.size()), 128'(0));
    f_en = 0; w_en = 0; f_rand_v = 0; f_rand_d = 0; w_rand_v = 0; w_rand_d = 0;
    repeat (4) @(negedge clk);
    #1;

    // Reset mid-packet at beat 5 of 10, then a fresh packet
    f_seq = 100; f_lim = 110; f_pkt = 10; f_in_cnt = 0; f_en = 1;
    while (f_in_cnt < 5 && cyc < 100_000) begin
      @(negedge clk); #1;
    end
    check("midrst_tvalid_before", 128'(f_m.tvalid), 128'(1));
    aresetn = 1'b0; f_en = 0;
    #1;
    check("midrst_tvalid_now", 128'(f_m.tvalid), 128'(0));
    check("midrst_tready_now", 128'(f_s.tready), 128'(0));
    repeat (2) @(negedge clk);
    #1;
    aresetn = 1'b1;
    @(negedge clk); #1;
    check("midrst_tready_back", 128'(f_s.tready), 128'(1));
    f_seq = 200; f_lim = 210; f_pkt = 10; f_out_cnt = 0; f_exact = 1;
    t0 = cyc + 1;
    f_en = 1;
    wait_outs("midrst_fresh_wait", 10, 0, 100);
    for (int k = 0; k < 10; k++) begin
      check("midrst_fresh_data", f_log_d[k], 128'(200 + k));
      check("midrst_fresh_last", 128'(f_log_l[k]), 128'(k == 9));
    end
    check("midrst_fresh_first_cycle", 128'(f_log_c[0]), 128'(t0 + 3));
    f_en = 0; f_exact = 0;
    repeat (4) @(negedge clk);
    #1;
    check("final_full_empty", 128'(fq.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
